// File: rtl/count_event_fifo.sv
// Watches the upstream saturating counter and queues every value change as an event
// {value, timestamp} in a show-ahead FIFO; events lost to a full FIFO set a sticky ovf.
module count_event_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TS_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [3:0]                count_in,
   output logic                      evt_valid,
   input  logic                      evt_ready,
   output logic [3:0]                evt_value,
   output logic [TS_W-1:0]           evt_stamp,
   output logic                      evt_term,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      ovf
);

   localparam int unsigned   AW         = $clog2(DEPTH);
   localparam int unsigned   LW         = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
   localparam logic [3:0]    TERM_VALUE = 4'd12;

   logic [TS_W-1:0] ts_q;
   logic [3:0]      prev_q;
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [LW-1:0]   level_q;
   logic [LW-1:0]   level_d;
   logic            ovf_q;

   logic [3:0]      mem_value [DEPTH];
   logic [TS_W-1:0] mem_stamp [DEPTH];

   logic push_req;
   logic pop;
   logic push;

   // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
   always_comb begin
      push_req = (count_in != prev_q);
      pop      = (level_q != '0) & evt_ready;
      push     = push_req & ((level_q != FULL_LEVEL) | pop);
   end

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts_q     <= '0;
         prev_q   <= 4'h0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         ts_q    <= ts_q + TS_W'(1);
         prev_q  <= count_in;
         level_q <= level_d;
         ovf_q   <= ovf_q | (push_req & ~push);
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // Storage carries no reset; validity is tracked solely by level_q.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_value[wr_ptr_q] <= count_in;
         mem_stamp[wr_ptr_q] <= ts_q;
      end
   end

   assign evt_valid = (level_q != '0);
   assign evt_value = mem_value[rd_ptr_q];
   assign evt_stamp = mem_stamp[rd_ptr_q];
   assign evt_term  = (mem_value[rd_ptr_q] == TERM_VALUE);
   assign level     = level_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_count_event_fifo.sv
// Directed bench for count_event_fifo: reset, counting run, overflow, full+pop, stamp wrap,
// and asynchronous reset with queued entries.
module tb_count_event_fifo;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TS_W  = 8;

   typedef struct {
      logic [3:0]      v;
      logic [TS_W-1:0] s;
   } ent_t;

   logic                   clk;
   logic                   rst;
   logic [3:0]             count_in;
   logic                   evt_valid;
   logic                   evt_ready;
   logic [3:0]             evt_value;
   logic [TS_W-1:0]        evt_stamp;
   logic                   evt_term;
   logic [$clog2(DEPTH):0] level;
   logic                   ovf;

   int   n_checks;
   int   n_fail;
   ent_t exp_q [$];

   count_event_fifo #(
      .DEPTH (DEPTH),
      .TS_W  (TS_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .count_in  (count_in),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_value (evt_value),
      .evt_stamp (evt_stamp),
      .evt_term  (evt_term),
      .level     (level),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: run did not finish, got still running, expected finished");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset held across two edges, released just after an edge.
   task automatic do_reset(input logic [3:0] cin);
      rst       = 1'b0;
      count_in  = cin;
      evt_ready = 1'b0;
      exp_q.delete();
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic push_exp(input logic [3:0] v, input logic [TS_W-1:0] s);
      ent_t e;
      e.v = v;
      e.s = s;
      exp_q.push_back(e);
   endtask

   // Pops with evt_ready=1 (count_in held), comparing each head against exp_q.
   task automatic drain(input int n_exp, input int max_cycles);
      int   n_pop;
      ent_t e;
      n_pop     = 0;
      evt_ready = 1'b1;
      for (int i = 0; i < max_cycles; i++) begin
         if (evt_valid) begin
            n_pop++;
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_eq("drain_value", evt_value, e.v);
               check_eq("drain_stamp", evt_stamp, e.s);
               check_eq("drain_term", evt_term, e.v == 4'd12);
            end
         end
         tick();
      end
      check_eq("drain_count", n_pop, n_exp);
      check_eq("drain_empty", evt_valid, 0);
      evt_ready = 1'b0;
   endtask

   initial begin
      int n_evt;
      int exp_v;
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b0;
      count_in  = 4'd3;
      evt_ready = 1'b0;

      // Reset state and first event after reset
      tick();
      tick();
      check_eq("rst_valid", evt_valid, 0);
      check_eq("rst_level", level, 0);
      check_eq("rst_ovf", ovf, 0);
      rst       = 1'b1;
      evt_ready = 1'b1;
      tick();
      check_eq("first_valid", evt_valid, 1);
      check_eq("first_value", evt_value, 3);
      check_eq("first_stamp", evt_stamp, 0);
      check_eq("first_term", evt_term, 0);
      tick();
      check_eq("first_popped", evt_valid, 0);
      repeat (3) tick();
      check_eq("hold_no_event", evt_valid, 0);

      // Counting run 3..12 with consumer always ready
      do_reset(4'd3);
      evt_ready = 1'b1;
      n_evt     = 0;
      exp_v     = 3;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (evt_valid) begin
            check_eq("run_value", evt_value, exp_v);
            check_eq("run_stamp", evt_stamp, exp_v - 3);
            check_eq("run_term", evt_term, exp_v == 12);
            n_evt++;
            exp_v++;
         end
         check_eq("run_ovf", ovf, 0);
         if (count_in < 4'd12) count_in = count_in + 4'd1;
      end
      check_eq("run_count", n_evt, 10);

      // Overflow: six changes with consumer stalled
      do_reset(4'd0);
      for (int k = 1; k <= 6; k++) begin
         count_in = 4'(k);
         tick();
         check_eq("ovf_level", level, (k < 4) ? k : 4);
         check_eq("ovf_flag", ovf, (k >= 5) ? 1 : 0);
         if (k <= 4) push_exp(4'(k), TS_W'(k - 1));
      end
      drain(4, 8);
      check_eq("ovf_sticky", ovf, 1);

      // Full FIFO: pop and push on the same edge
      do_reset(4'd0);
      for (int k = 1; k <= 4; k++) begin
         count_in = 4'(k);
         tick();
         push_exp(4'(k), TS_W'(k - 1));
      end
      check_eq("full_level", level, 4);
      count_in  = 4'd7;
      evt_ready = 1'b1;
      tick();
      void'(exp_q.pop_front());
      push_exp(4'd7, 8'd4);
      check_eq("fullpp_level", level, 4);
      check_eq("fullpp_ovf", ovf, 0);
      check_eq("fullpp_head", evt_value, 2);
      drain(4, 8);
      check_eq("fullpp_ovf_after", ovf, 0);

      // Timestamp wrap: 300 quiet edges, then a change
      do_reset(4'd0);
      evt_ready = 1'b1;
      repeat (300) tick();
      check_eq("wrap_quiet", evt_valid, 0);
      count_in = 4'd9;
      tick();
      check_eq("wrap_valid", evt_valid, 1);
      check_eq("wrap_value", evt_value, 9);
      check_eq("wrap_stamp", evt_stamp, 44);

      // Asynchronous reset with three queued entries and ovf set
      do_reset(4'd0);
      for (int k = 1; k <= 5; k++) begin
         count_in = 4'(k);
         tick();
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check_eq("pre_rst_level", level, 3);
      check_eq("pre_rst_ovf", ovf, 1);
      #3;
      rst = 1'b0;
      #1;
      check_eq("async_valid", evt_valid, 0);
      check_eq("async_level", level, 0);
      check_eq("async_ovf", ovf, 0);
      count_in = 4'd7;
      tick();
      rst = 1'b1;
      tick();
      check_eq("post_rst_valid", evt_valid, 1);
      check_eq("post_rst_value", evt_value, 7);
      check_eq("post_rst_stamp", evt_stamp, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
